// File: rtl/img_pkg.sv
// Shared types and sizing for the image raster reader.
// Holds the reader FSM encoding and the per-pixel tag.
package img_pkg;

    localparam int PIX_W      = 8;
    localparam int IMG_X_MAX  = 400;
    localparam int IMG_Y_MAX  = 400;
    localparam int COL_W      = $clog2(IMG_X_MAX);
    localparam int ROW_W      = $clog2(IMG_Y_MAX);
    localparam int IMG_ADDR_W = $clog2(IMG_X_MAX * IMG_Y_MAX);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } reader_state_t;

    typedef struct packed {
        logic [COL_W-1:0] x;
        logic [ROW_W-1:0] y;
        logic             last;
    } pix_tag_t;

endpackage

// File: rtl/img_raster_reader_fifo.sv
// Two-entry FIFO holding returned pixels with their raster tags.
// Output is taken straight from storage registers.
module pix_skid_fifo
    import img_pkg::*;
#(
    parameter int DW = PIX_W
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          push,
    input  logic [DW-1:0] push_pix,
    input  pix_tag_t      push_tag,
    input  logic          pop,
    output logic [DW-1:0] pop_pix,
    output pix_tag_t      pop_tag,
    output logic [1:0]    count,
    output logic          empty,
    output logic          full
);

    logic [1:0][DW-1:0] mem_pix;
    pix_tag_t [1:0]     mem_tag;
    logic               wr_ptr;
    logic               rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'd2);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_pix = mem_pix[rd_ptr];
    assign pop_tag = mem_tag[rd_ptr];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mem_pix <= '0;
            mem_tag <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
        end else begin
            if (do_push) begin
                mem_pix[wr_ptr] <= push_pix;
                mem_tag[wr_ptr] <= push_tag;
                wr_ptr          <= !wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= !rd_ptr;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/img_raster_reader.sv
// Raster-scans the image SRAM and streams tagged pixels downstream.
// Reads are credit-limited so a stalled consumer never loses data.
module img_raster_reader
    import img_pkg::*;
#(
    parameter int BIT_DEPTH = PIX_W,
    parameter int X_MAX     = IMG_X_MAX,
    parameter int Y_MAX     = IMG_Y_MAX,
    parameter int ADDR_W    = $clog2(X_MAX * Y_MAX)
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     new_trans,
    input  logic [$clog2(X_MAX)-1:0] max_x,
    input  logic [$clog2(Y_MAX)-1:0] max_y,
    output logic                     img_done,
    output logic                     busy,
    output logic                     ren_img,
    output logic [ADDR_W-1:0]        addr_img,
    input  logic [BIT_DEPTH-1:0]     rdat_img,
    output logic                     pix_valid,
    input  logic                     pix_ready,
    output logic [BIT_DEPTH-1:0]     pix_data,
    output logic [$clog2(X_MAX)-1:0] pix_x,
    output logic [$clog2(Y_MAX)-1:0] pix_y,
    output logic                     pix_last
);

    localparam int XW = $clog2(X_MAX);
    localparam int YW = $clog2(Y_MAX);

    reader_state_t   state;
    logic [XW-1:0]   mx;
    logic [YW-1:0]   my;
    logic [XW-1:0]   x_cnt;
    logic [YW-1:0]   y_cnt;
    logic [ADDR_W-1:0] addr;
    logic            inflight;
    pix_tag_t        tag_q;
    logic [XW-1:0]   dx;
    logic [YW-1:0]   dy;
    logic            x_wrap;
    logic            last_rd;
    logic            pop;
    pix_tag_t        out_tag;
    logic [1:0]      fifo_count;
    logic            fifo_empty;
    logic            fifo_full;

    assign dx      = (max_x > XW'(X_MAX)) ? XW'(X_MAX) : max_x;
    assign dy      = (max_y > YW'(Y_MAX)) ? YW'(Y_MAX) : max_y;
    assign x_wrap  = (x_cnt == mx - XW'(1));
    assign last_rd = x_wrap && (y_cnt == my - YW'(1));

    // Outstanding = buffered + returning next cycle; never exceed FIFO depth.
    assign ren_img = (state == FETCH) && !fifo_full &&
                     ((fifo_count + 2'(inflight)) < 2'd2);
    assign addr_img = addr;

    assign pix_valid = !fifo_empty;
    assign pop       = pix_valid && pix_ready;
    assign pix_x     = out_tag.x;
    assign pix_y     = out_tag.y;
    assign pix_last  = out_tag.last;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            mx       <= '0;
            my       <= '0;
            x_cnt    <= '0;
            y_cnt    <= '0;
            addr     <= '0;
            inflight <= 1'b0;
            tag_q    <= '0;
            img_done <= 1'b0;
            busy     <= 1'b0;
        end else begin
            inflight <= ren_img;
            if (ren_img) begin
                tag_q.x    <= x_cnt;
                tag_q.y    <= y_cnt;
                tag_q.last <= last_rd;
                addr       <= addr + ADDR_W'(1);
                if (!last_rd) begin
                    if (x_wrap) begin
                        x_cnt <= '0;
                        y_cnt <= y_cnt + YW'(1);
                    end else begin
                        x_cnt <= x_cnt + XW'(1);
                    end
                end
            end
            unique case (state)
                IDLE: begin
                    if (new_trans) begin
                        mx    <= dx;
                        my    <= dy;
                        x_cnt <= '0;
                        y_cnt <= '0;
                        addr  <= '0;
                        busy  <= 1'b1;
                        state <= (dx == '0 || dy == '0) ? DONE : FETCH;
                    end
                end
                FETCH: begin
                    if (ren_img && last_rd) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!inflight &&
                        (fifo_empty || (fifo_count == 2'd1 && pop))) begin
                        state    <= DONE;
                        img_done <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                DONE: begin
                    // Empty frames arrive with img_done low and pulse one cycle later.
                    if (img_done) begin
                        img_done <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        img_done <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    pix_skid_fifo #(
        .DW(BIT_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .n_rst    (n_rst),
        .push     (inflight),
        .push_pix (rdat_img),
        .push_tag (tag_q),
        .pop      (pop),
        .pop_pix  (pix_data),
        .pop_tag  (out_tag),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

endmodule

// File: tb/tb_img_raster_reader.sv
// Randomized self-checking bench for img_raster_reader.
// Expected frames are derived from raster arithmetic on the dims.
module tb_img_raster_reader;

    localparam int XW = 9;
    localparam int YW = 9;
    localparam int AW = 18;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          new_trans = 1'b0;
    logic [XW-1:0] max_x = '0;
    logic [YW-1:0] max_y = '0;
    logic          img_done;
    logic          busy;
    logic          ren_img;
    logic [AW-1:0] addr_img;
    logic [7:0]    rdat_img = '0;
    logic          pix_valid;
    logic          pix_ready = 1'b1;
    logic [7:0]    pix_data;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          pix_last;

    img_raster_reader dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .new_trans (new_trans),
        .max_x     (max_x),
        .max_y     (max_y),
        .img_done  (img_done),
        .busy      (busy),
        .ren_img   (ren_img),
        .addr_img  (addr_img),
        .rdat_img  (rdat_img),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_data  (pix_data),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_last  (pix_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d;
        int x;
        int y;
        int l;
        int c;
    } px_t;

    int  seed = 0;
    int  cyc = 0;
    int  rd_q[$];
    int  rd_c[$];
    px_t px_q[$];
    int  done_cnt = 0;
    int  done_cyc = 0;
    int  done_busy = 0;
    int  cred_err = 0;
    int  stab_err = 0;
    int  issued = 0;
    int  accepted = 0;
    logic       stall_q = 1'b0;
    logic [7:0] sd = '0;
    logic [XW-1:0] sx = '0;
    logic [YW-1:0] sy = '0;
    logic       sl = 1'b0;

    int checks = 0;
    int errors = 0;
    int b_rd, b_px, b_done, b_cred, b_stab, nt_cyc;

    function automatic logic [7:0] pixel_of(input int a);
        return 8'((a * 151 + seed) ^ (a >> 5));
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ren_img) rdat_img <= pixel_of(int'(addr_img));
    end

    always @(negedge clk) begin
        if (!n_rst) begin
            accepted <= issued;
            stall_q  <= 1'b0;
        end else begin
            if (ren_img) begin
                if (issued - accepted >= 2) cred_err <= cred_err + 1;
                rd_q.push_back(int'(addr_img));
                rd_c.push_back(cyc);
            end
            if (stall_q && (!pix_valid || pix_data !== sd || pix_x !== sx ||
                            pix_y !== sy || pix_last !== sl))
                stab_err <= stab_err + 1;
            stall_q <= pix_valid && !pix_ready;
            sd <= pix_data;
            sx <= pix_x;
            sy <= pix_y;
            sl <= pix_last;
            if (pix_valid && pix_ready)
                px_q.push_back('{int'(pix_data), int'(pix_x), int'(pix_y),
                                 int'(pix_last), cyc});
            issued   <= issued + int'(ren_img);
            accepted <= accepted + int'(pix_valid && pix_ready);
            if (img_done) begin
                done_cnt  <= done_cnt + 1;
                done_cyc  <= cyc;
                done_busy <= int'(busy);
            end
        end
    end

    task automatic tick(input int mode);
        @(posedge clk);
        #1;
        new_trans = 1'b0;
        if (mode == 0) pix_ready = 1'b1;
        else if (mode == 1) pix_ready = cyc[0];
        else pix_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic snap();
        b_rd   = rd_q.size();
        b_px   = px_q.size();
        b_done = done_cnt;
        b_cred = cred_err;
        b_stab = stab_err;
    endtask

    task automatic launch(input int mx, input int my);
        new_trans = 1'b1;
        max_x     = XW'(mx);
        max_y     = YW'(my);
        nt_cyc    = cyc;
    endtask

    task automatic wait_done(input string nm, input int mode, input int budget);
        int n = 0;
        while (done_cnt == b_done && n < budget) begin
            tick(mode);
            n++;
        end
        checks++;
        if (done_cnt == b_done) begin
            errors++;
            $display("FAIL %s timeout got=no_done exp=done within %0d", nm, budget);
        end
        repeat (4) tick(mode);
    endtask

    task automatic check_frame(input string nm, input int mx, input int my);
        int ex = (mx > 400) ? 400 : mx;
        int ey = (my > 400) ? 400 : my;
        int n = ex * ey;
        int nr = rd_q.size() - b_rd;
        int np = px_q.size() - b_px;
        int bad = -1;
        int exp_c;
        int got_c;
        px_t p;
        checks++;
        if (nr != n) begin
            errors++;
            $display("FAIL %s read_count got=%0d exp=%0d", nm, nr, n);
        end
        for (int i = 0; i < n && i < nr; i++)
            if (bad < 0 && rd_q[b_rd + i] != i) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s addr[%0d] got=%0d exp=%0d", nm, bad, rd_q[b_rd + bad], bad);
        end
        checks++;
        if (np != n) begin
            errors++;
            $display("FAIL %s pixel_count got=%0d exp=%0d", nm, np, n);
        end
        bad = -1;
        for (int i = 0; i < n && i < np; i++) begin
            p = px_q[b_px + i];
            if (bad < 0 && (p.d != int'(pixel_of(i)) || p.x != i % ex ||
                            p.y != i / ex || p.l != int'(i == n - 1)))
                bad = i;
        end
        checks++;
        if (bad >= 0) begin
            p = px_q[b_px + bad];
            errors++;
            $display("FAIL %s pixel[%0d] got=d%0d x%0d y%0d l%0d exp=d%0d x%0d y%0d l%0d",
                     nm, bad, p.d, p.x, p.y, p.l, pixel_of(bad), bad % ex,
                     bad / ex, int'(bad == n - 1));
        end
        checks++;
        if (done_cnt - b_done != 1) begin
            errors++;
            $display("FAIL %s done_pulses got=%0d exp=1", nm, done_cnt - b_done);
        end
        if (n > 0) exp_c = (np > 0) ? px_q[px_q.size() - 1].c + 1 : -1;
        else exp_c = nt_cyc + 2;
        got_c = done_cyc;
        checks++;
        if (got_c != exp_c) begin
            errors++;
            $display("FAIL %s done_cycle got=%0d exp=%0d", nm, got_c, exp_c);
        end
        checks++;
        if (cred_err != b_cred || stab_err != b_stab) begin
            errors++;
            $display("FAIL %s credit_stable got=%0d/%0d exp=0/0", nm,
                     cred_err - b_cred, stab_err - b_stab);
        end
        checks++;
        if (done_busy != 0) begin
            errors++;
            $display("FAIL %s busy_at_done got=%0d exp=0", nm, done_busy);
        end
    endtask

    task automatic do_frame(input string nm, input int mx, input int my, input int mode);
        int ex = (mx > 400) ? 400 : mx;
        int ey = (my > 400) ? 400 : my;
        tick(mode);
        snap();
        launch(mx, my);
        wait_done(nm, mode, ex * ey * 6 + 40);
        check_frame(nm, mx, my);
    endtask

    task automatic test_reset();
        logic [AW+XW+YW+13:0] v;
        repeat (3) tick(0);
        v = {img_done, busy, ren_img, addr_img, pix_valid, pix_data, pix_x, pix_y, pix_last};
        checks++;
        if (v !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", v);
        end
        n_rst = 1'b1;
        repeat (3) tick(0);
        checks++;
        if ({busy, ren_img, pix_valid, img_done} !== 4'b0) begin
            errors++;
            $display("FAIL idle_after_reset got=%b exp=0000", {busy, ren_img, pix_valid, img_done});
        end
    endtask

    task automatic test_frame_4x3();
        do_frame("f4x3", 4, 3, 0);
        checks++;
        if (rd_c.size() <= b_rd || rd_c[b_rd] != nt_cyc + 1) begin
            errors++;
            $display("FAIL first_ren got=%0d exp=%0d", rd_c.size() > b_rd ? rd_c[b_rd] : -1, nt_cyc + 1);
        end
        checks++;
        if (px_q.size() <= b_px || px_q[b_px].c != nt_cyc + 3) begin
            errors++;
            $display("FAIL first_valid got=%0d exp=%0d", px_q.size() > b_px ? px_q[b_px].c : -1, nt_cyc + 3);
        end
    endtask

    task automatic test_back_to_back();
        do_frame("toggle4x3", 4, 3, 1);
        do_frame("b2b4x3", 4, 3, 0);
    endtask

    task automatic test_zero_dims();
        do_frame("zero_x", 0, 3, 0);
        do_frame("zero_y", 5, 0, 2);
    endtask

    task automatic test_thin();
        do_frame("f1x1", 1, 1, 0);
        do_frame("f1x5", 1, 5, 1);
    endtask

    task automatic test_reissue();
        tick(1);
        snap();
        launch(4, 3);
        repeat (3) tick(1);
        new_trans = 1'b1;
        max_x = 9'd9;
        max_y = 9'd9;
        wait_done("reissue", 1, 120);
        check_frame("reissue", 4, 3);
    endtask

    task automatic test_midframe_reset();
        logic [AW+XW+YW+13:0] v;
        tick(0);
        snap();
        launch(4, 3);
        repeat (5) tick(0);
        n_rst = 1'b0;
        #1;
        v = {img_done, busy, ren_img, addr_img, pix_valid, pix_data, pix_x, pix_y, pix_last};
        checks++;
        if (v !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got=%h exp=0", v);
        end
        repeat (2) tick(0);
        n_rst = 1'b1;
        repeat (12) tick(0);
        checks++;
        if (done_cnt != b_done || busy !== 1'b0 || pix_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_quiet got=done%0d busy%b valid%b exp=done0 busy0 valid0",
                     done_cnt - b_done, busy, pix_valid);
        end
        do_frame("after_reset", 3, 2, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) begin
            seed = int'($urandom_range(0, 255));
            do_frame("rand", int'($urandom_range(1, 10)), int'($urandom_range(1, 10)), 2);
        end
    endtask

    task automatic test_limits();
        do_frame("clamp511x2", 511, 2, 0);
        do_frame("clamp2x511", 2, 511, 2);
        do_frame("f400x3", 400, 3, 1);
    endtask

    initial begin
        seed = int'($urandom_range(0, 255));
        test_reset();
        test_frame_4x3();
        test_back_to_back();
        test_zero_dims();
        test_thin();
        test_reissue();
        test_midframe_reset();
        test_random();
        test_limits();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
